stage4_mem_lsu: RTL and testbench
=================================

// Module: stage4_mem_lsu
// PURPOSE
//  Parametrised MEM stage, successor of the fixed-width stage4 MEM. Sits between EX and WB.
//  Waits for a data-SRAM response (data_ok) before advancing, buffers early responses, and
//  aligns/extends byte, half and word loads. Discards responses owed to flushed instructions.
//  Drives the forward/stall bus to ID.
// PARAMETERS
//  PC_W            32  width of pc field
//  DEST_W          5   width of destination register index
//  MAX_OUTST       2   max responses pending discard; range 1..7
//  (ES_W = PC_W+DEST_W+40, WS_W = PC_W+DEST_W+33, DS_W = DEST_W+34; data fixed 32b)
// PORTS
//  clk                in   1      clock, rising edge
//  resetn             in   1      asynchronous, active-low reset
//  es_to_ms_valid     in   1      EX holds a valid instruction
//  ms_allow_in        out  1      MEM accepts from EX this cycle
//  es_to_ms_bus       in   ES_W   {alu_result[31:0], dest, req_issued, addr_lo[1:0], mem_op[2:0], res_from_mem, gr_we, pc}
//  ms_flush           in   1      kill the MEM entry (exception/ertn)
//  data_sram_data_ok  in   1      one in-order read/write response this cycle
//  data_sram_rdata    in   32     response data, valid with data_ok
//  ws_allow_in        in   1      WB accepts
//  ms_to_ws_valid     out  1      MEM result valid to WB
//  ms_to_ws_bus       out  WS_W   {final_result[31:0], dest, gr_we, pc}
//  ms_to_ds_bus       out  DS_W   {ld_pending, we_valid, dest, final_result[31:0]}
//  ms_stall_cnt       out  32     cycles stalled on data_ok (only with MS_STALL_CNT_EN)
// BEHAVIOUR
//  Reset: ms_valid=0, got_data=0, rdata_buf=0, bus reg=0, discard_cnt=0. ms_allow_in=1, ms_to_ws_valid=0, ms_to_ds_bus=0.
//  Bus reg loads when es_to_ms_valid && ms_allow_in && !ms_flush; otherwise holds (it is not zeroed).
//  ms_valid: flush -> 0; else if ms_allow_in -> es_to_ms_valid.
//  resp_ok = data_ok && discard_cnt==0 (own response); resp_ok with no valid waiting entry is a protocol error.
//  ms_ready_go = !req_issued || got_data || resp_ok.
//  ms_allow_in = (!ms_valid || ms_ready_go && ws_allow_in) && discard_cnt!=MAX_OUTST.
//  ms_to_ws_valid = ms_valid && ms_ready_go && !ms_flush.
//  Per-entry states:
//   WAIT: req_issued && !got_data.
//   HELD: got_data.
//   DONE: entry leaves.
//  WAIT->HELD: resp_ok && !ws_allow_in; rdata_buf<=rdata.
//  WAIT->DONE: resp_ok && ws_allow_in; data passes straight through with zero added latency.
//  got_data is cleared when the entry leaves or is flushed.
//  raw = got_data ? rdata_buf : data_sram_rdata. sh = addr_lo*8.
//  mem_op encodings:
//   000 LW: raw.
//   001 LB: sext(raw>>sh)[7:0].
//   101 LBU: zext(raw>>sh)[7:0].
//   010 LH: sext(raw>>{addr_lo[1],4'b0})[15:0].
//   110 LHU: zext of the same.
//  final_result = res_from_mem ? extended : alu_result.
//  ld_pending = ms_valid && res_from_mem && !ms_ready_go. ID must stall on a matching dest.
//  we_valid = ms_valid && gr_we.
//  Flush of a WAIT entry with no same-cycle resp_ok: discard_cnt+1.
//  data_ok while discard_cnt>0: discard_cnt-1, response dropped, got_data unchanged.
//  Increment and decrement in the same cycle: count unchanged.
//  discard_cnt==MAX_OUTST blocks ms_allow_in.
//  Flush of a HELD entry, or one with same-cycle resp_ok: nothing to discard.
//  resetn low mid-wait: all state cleared at once; the outstanding response is not tracked.
// CONFIGURATION
//  MS_STALL_CNT_EN defined: 32b ms_stall_cnt increments each cycle ms_valid && req_issued && !ms_ready_go.
//   It wraps at 2^32-1->0 and resets to 0.
//  MS_STALL_CNT_EN undefined: the port and the counter are absent. All other behaviour is identical.
// TESTING
//  LW, req_issued=1, data_ok same cycle as entry, ws_allow_in=1 -> ms_to_ws_valid that cycle, result=rdata.
//  LB addr_lo=3, rdata=32'h80AA_BBCC, data_ok 3 cycles late -> ld_pending=1 for 3 cycles, result=32'hFFFF_FF80.
//  LHU addr_lo=2, rdata=32'h8001_1234, ws_allow_in=0 at data_ok -> HELD; ws_allow_in next cycle -> result=32'h0000_8001.
//  Flush a WAIT LW, next entry LW -> first data_ok dropped, discard_cnt 1->0, second entry gets the next data_ok.
//  MAX_OUTST=1: flush a WAIT entry -> ms_allow_in=0 until data_ok; flush+data_ok in the same cycle -> discard_cnt stays 0.
//  resetn low while in WAIT -> ms_to_ws_valid=0, ms_allow_in=1, ms_to_ds_bus=0 immediately; stall_cnt=0 (MS_STALL_CNT_EN).

Source files
------------

// File: rtl/stage4_mem_lsu.sv
// MEM stage between EX and WB: waits for the data-SRAM response, aligns/extends loads, drops responses of flushed entries.
// Latency: zero added cycles; a same-cycle response passes straight to WB. Optional stall counter under MS_STALL_CNT_EN.
// Backpressure: holds the entry while waiting for data_ok or ws_allow_in; refuses EX while MAX_OUTST stale responses are owed.
module stage4_mem_lsu #(
    parameter int PC_W      = 32,
    parameter int DEST_W    = 5,
    parameter int MAX_OUTST = 2,
    localparam int ES_W     = PC_W + DEST_W + 40,
    localparam int WS_W     = PC_W + DEST_W + 33,
    localparam int DS_W     = DEST_W + 34,
    localparam int CW       = $clog2(MAX_OUTST + 1)
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            es_to_ms_valid,
    output logic            ms_allow_in,
    input  logic [ES_W-1:0] es_to_ms_bus,
    input  logic            ms_flush,
    input  logic            data_sram_data_ok,
    input  logic [31:0]     data_sram_rdata,
    input  logic            ws_allow_in,
    output logic            ms_to_ws_valid,
    output logic [WS_W-1:0] ms_to_ws_bus,
    output logic [DS_W-1:0] ms_to_ds_bus
`ifdef MS_STALL_CNT_EN
    ,
    output logic [31:0]     ms_stall_cnt
`endif
);

    logic [ES_W-1:0] bus_q;
    logic            ms_valid_q, ms_valid_d;
    logic            got_data_q, got_data_d;
    logic [31:0]     rdata_buf_q, rdata_buf_d;
    logic [CW-1:0]   discard_q, discard_d;

    logic [31:0]       alu_result;
    logic [DEST_W-1:0] dest;
    logic              req_issued;
    logic [1:0]        addr_lo;
    logic [2:0]        mem_op;
    logic              res_from_mem;
    logic              gr_we;
    logic [PC_W-1:0]   pc;

    assign {alu_result, dest, req_issued, addr_lo, mem_op, res_from_mem, gr_we, pc} = bus_q;

    logic resp_ok, ms_ready_go, load_en, leave, waiting, disc_inc, disc_dec;

    // A response only belongs to the current entry once every stale one has been drained.
    assign resp_ok        = data_sram_data_ok && (discard_q == '0);
    assign ms_ready_go    = !req_issued || got_data_q || resp_ok;
    assign ms_allow_in    = (!ms_valid_q || (ms_ready_go && ws_allow_in))
                            && (discard_q != CW'(MAX_OUTST));
    assign ms_to_ws_valid = ms_valid_q && ms_ready_go && !ms_flush;
    assign load_en        = es_to_ms_valid && ms_allow_in && !ms_flush;
    assign leave          = ms_to_ws_valid && ws_allow_in;
    assign waiting        = ms_valid_q && req_issued && !got_data_q;
    assign disc_inc       = ms_flush && waiting && !resp_ok;
    assign disc_dec       = data_sram_data_ok && (discard_q != '0);

    always_comb begin
        ms_valid_d  = ms_valid_q;
        got_data_d  = got_data_q;
        rdata_buf_d = rdata_buf_q;
        discard_d   = discard_q;
        if (ms_flush) begin
            ms_valid_d = 1'b0;
        end else if (ms_allow_in) begin
            ms_valid_d = es_to_ms_valid;
        end
        if (ms_flush || leave) begin
            got_data_d = 1'b0;
        end else if (waiting && resp_ok) begin
            got_data_d  = 1'b1;
            rdata_buf_d = data_sram_rdata;
        end
        if (disc_inc && !disc_dec) begin
            discard_d = discard_q + 1'b1;
        end else if (disc_dec && !disc_inc) begin
            discard_d = discard_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bus_q       <= '0;
            ms_valid_q  <= 1'b0;
            got_data_q  <= 1'b0;
            rdata_buf_q <= '0;
            discard_q   <= '0;
        end else begin
            ms_valid_q  <= ms_valid_d;
            got_data_q  <= got_data_d;
            rdata_buf_q <= rdata_buf_d;
            discard_q   <= discard_d;
            if (load_en) begin
                bus_q <= es_to_ms_bus;
            end
        end
    end

    logic [31:0] raw, mem_ext, final_result;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic        ld_pending, we_valid;

    assign raw    = got_data_q ? rdata_buf_q : data_sram_rdata;
    assign half_v = addr_lo[1] ? raw[31:16] : raw[15:0];

    always_comb begin
        byte_v = raw[7:0];
        case (addr_lo)
            2'd1:    byte_v = raw[15:8];
            2'd2:    byte_v = raw[23:16];
            2'd3:    byte_v = raw[31:24];
            default: byte_v = raw[7:0];
        endcase
    end

    // Unlisted encodings fall back to the full word.
    always_comb begin
        mem_ext = raw;
        case (mem_op)
            3'b001:  mem_ext = {{24{byte_v[7]}}, byte_v};
            3'b101:  mem_ext = {24'd0, byte_v};
            3'b010:  mem_ext = {{16{half_v[15]}}, half_v};
            3'b110:  mem_ext = {16'd0, half_v};
            default: mem_ext = raw;
        endcase
    end

    assign final_result = res_from_mem ? mem_ext : alu_result;
    assign ld_pending   = ms_valid_q && res_from_mem && !ms_ready_go;
    assign we_valid     = ms_valid_q && gr_we;
    assign ms_to_ws_bus = {final_result, dest, gr_we, pc};
    assign ms_to_ds_bus = {ld_pending, we_valid, dest, final_result};

`ifdef MS_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stall_cnt_q <= '0;
        end else if (ms_valid_q && req_issued && !ms_ready_go) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign ms_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_stage4_mem_lsu.sv
// Bench for stage4_mem_lsu: directed cases then random traffic against a transaction-level model
// (one MEM slot plus an in-order SRAM response queue whose items are marked dead when their owner is flushed).
module tb_stage4_mem_lsu;
    localparam int PC_W      = 32;
    localparam int DEST_W    = 5;
    localparam int MAX_OUTST = 2;
    localparam int ES_W      = PC_W + DEST_W + 40;
    localparam int WS_W      = PC_W + DEST_W + 33;
    localparam int DS_W      = DEST_W + 34;

    logic            clk = 1'b0;
    logic            resetn;
    logic            es_to_ms_valid;
    logic            ms_allow_in;
    logic [ES_W-1:0] es_to_ms_bus;
    logic            ms_flush;
    logic            data_sram_data_ok;
    logic [31:0]     data_sram_rdata;
    logic            ws_allow_in;
    logic            ms_to_ws_valid;
    logic [WS_W-1:0] ms_to_ws_bus;
    logic [DS_W-1:0] ms_to_ds_bus;
`ifdef MS_STALL_CNT_EN
    logic [31:0]     ms_stall_cnt;
`endif

    stage4_mem_lsu #(.PC_W(PC_W), .DEST_W(DEST_W), .MAX_OUTST(MAX_OUTST)) dut (
        .clk               (clk),
        .resetn            (resetn),
        .es_to_ms_valid    (es_to_ms_valid),
        .ms_allow_in       (ms_allow_in),
        .es_to_ms_bus      (es_to_ms_bus),
        .ms_flush          (ms_flush),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .ws_allow_in       (ws_allow_in),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_to_ws_bus      (ms_to_ws_bus),
        .ms_to_ds_bus      (ms_to_ds_bus)
`ifdef MS_STALL_CNT_EN
        ,
        .ms_stall_cnt      (ms_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] alu;
        logic [4:0]  dest;
        logic        req;
        logic [1:0]  lo;
        logic [2:0]  op;
        logic        rfm;
        logic        we;
        logic [31:0] pc;
        logic [31:0] rd;   // data the SRAM returns for this instruction
    } ins_t;

    int unsigned n_cmp = 0;
    int unsigned n_mis = 0;
    int unsigned n_retired = 0;

    ins_t        m_ins;
    bit          m_has = 0;
    bit          m_got = 0;
    logic [31:0] q_dat[$];
    bit          q_dead[$];
    int unsigned m_stall = 0;

    logic [31:0] last_res;
    bit          last_v, last_allow, last_acc, last_ldp;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [ES_W-1:0] pack(input ins_t i);
        return {i.alu, i.dest, i.req, i.lo, i.op, i.rfm, i.we, i.pc};
    endfunction

    function automatic logic [31:0] ref_res(input ins_t i);
        int unsigned d, b, h, lo;
        if (!i.rfm) return i.alu;
        d  = i.rd;
        lo = 32'(i.lo);
        b  = (d >> (8 * lo)) % 256;
        h  = (d >> (16 * (lo / 2))) % 65536;
        case (i.op)
            3'b001:  return (b >= 128) ? b + 32'hFFFF_FF00 : b;
            3'b101:  return b;
            3'b010:  return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            3'b110:  return h;
            default: return d;
        endcase
    endfunction

    function automatic ins_t mk(input logic [2:0] op, input logic [1:0] lo,
                                input logic [31:0] rd, input logic [31:0] pc);
        ins_t i;
        i.alu = 32'hDEAD_0000 ^ pc; i.dest = 5'(pc[6:2]); i.req = 1'b1; i.lo = lo;
        i.op = op; i.rfm = 1'b1; i.we = 1'b1; i.pc = pc; i.rd = rd;
        return i;
    endfunction

    function automatic ins_t rand_ins(input int unsigned id);
        ins_t i;
        logic [2:0] ops [5] = '{3'b000, 3'b001, 3'b101, 3'b010, 3'b110};
        int unsigned k = $urandom_range(0, 3);
        i.alu = $urandom; i.dest = 5'($urandom); i.pc = id * 4; i.lo = 2'($urandom);
        i.rd = $urandom; i.we = 1'($urandom); i.op = 3'($urandom);
        if (k == 0) begin
            i.req = 1'b0; i.rfm = 1'b0;
        end else if (k == 1) begin
            i.req = 1'b1; i.rfm = 1'b0; i.we = 1'b0;
        end else begin
            i.req = 1'b1; i.rfm = 1'b1; i.we = 1'b1; i.op = ops[$urandom_range(0, 4)];
        end
        return i;
    endfunction

    // One clock cycle: drive at posedge+1, compare mid-cycle, advance the model across the edge.
    task automatic step(input bit ev, input ins_t e, input bit fl, input bit wa, input bit dk);
        bit resp, rdy, exp_v, exp_allow, waiting, leave;
        int dead;
        es_to_ms_valid    = ev;
        es_to_ms_bus      = pack(e);
        ms_flush          = fl;
        ws_allow_in       = wa;
        data_sram_data_ok = dk && (q_dat.size() > 0);
        data_sram_rdata   = data_sram_data_ok ? q_dat[0] : $urandom;
        #3;
        resp = data_sram_data_ok && (q_dead.size() > 0) && !q_dead[0];
        dead = 0;
        foreach (q_dead[i]) if (q_dead[i]) dead++;
        rdy       = m_has && (!m_ins.req || m_got || resp);
        exp_v     = rdy && !fl;
        exp_allow = (!m_has || (rdy && wa)) && (dead != MAX_OUTST);
        check("allow_in", 64'(ms_allow_in), 64'(exp_allow));
        check("ws_valid", 64'(ms_to_ws_valid), 64'(exp_v));
        check("ld_pending", 64'(ms_to_ds_bus[DS_W-1]), 64'(m_has && m_ins.rfm && !rdy));
        check("we_valid", 64'(ms_to_ds_bus[DS_W-2]), 64'(m_has && m_ins.we));
        if (m_has) check("ds_dest", 64'(ms_to_ds_bus[36:32]), 64'(m_ins.dest));
        if (exp_v) begin
            check("ws_result", 64'(ms_to_ws_bus[69:38]), 64'(ref_res(m_ins)));
            check("ws_dest", 64'(ms_to_ws_bus[37:33]), 64'(m_ins.dest));
            check("ws_we", 64'(ms_to_ws_bus[32]), 64'(m_ins.we));
            check("ws_pc", 64'(ms_to_ws_bus[31:0]), 64'(m_ins.pc));
            check("ds_result", 64'(ms_to_ds_bus[31:0]), 64'(ref_res(m_ins)));
        end
`ifdef MS_STALL_CNT_EN
        check("stall_cnt", 64'(ms_stall_cnt), 64'(m_stall));
        if (m_has && m_ins.req && !rdy) m_stall++;
`endif
        last_res   = ms_to_ws_bus[69:38];
        last_v     = ms_to_ws_valid;
        last_allow = ms_allow_in;
        last_ldp   = ms_to_ds_bus[DS_W-1];
        waiting = m_has && m_ins.req && !m_got;
        if (data_sram_data_ok) begin
            void'(q_dat.pop_front());
            void'(q_dead.pop_front());
            if (resp) m_got = 1;
        end
        leave = exp_v && wa;
        if (m_has && (fl || leave)) begin
            if (fl && waiting && !resp) q_dead[q_dead.size()-1] = 1;
            if (leave) n_retired++;
            m_has = 0;
        end
        last_acc = ev && exp_allow && !fl;
        if (last_acc) begin
            m_has = 1; m_got = 0; m_ins = e;
            if (e.req) begin
                q_dat.push_back(e.rd);
                q_dead.push_back(1'b0);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        ins_t a, b, c, d, g;
        int unsigned ldp_cycles;
        int unsigned id;
        bit ev, fl, wa, dk;
        resetn = 1'b0; es_to_ms_valid = 1'b0; es_to_ms_bus = '0; ms_flush = 1'b0;
        data_sram_data_ok = 1'b0; data_sram_rdata = '0; ws_allow_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_allow", 64'(ms_allow_in), 64'd1);
        check("rst_ws_valid", 64'(ms_to_ws_valid), 64'd0);
        check("rst_ds_bus", 64'(ms_to_ds_bus), 64'd0);
`ifdef MS_STALL_CNT_EN
        check("rst_stall", 64'(ms_stall_cnt), 64'd0);
`endif
        resetn = 1'b1;

        // LW answered in its first MEM cycle
        a = mk(3'b000, 2'd0, 32'h1234_5678, 32'h100);
        step(1, a, 0, 1, 0);
        step(0, a, 0, 1, 1);
        check("lw_same_cycle_v", 64'(last_v), 64'd1);
        check("lw_same_cycle_res", 64'(last_res), 64'h1234_5678);

        // LB, response three cycles late
        a = mk(3'b001, 2'd3, 32'h80AA_BBCC, 32'h104);
        step(1, a, 0, 1, 0);
        ldp_cycles = 0;
        repeat (3) begin
            step(0, a, 0, 1, 0);
            ldp_cycles += 32'(last_ldp);
        end
        step(0, a, 0, 1, 1);
        check("lb_ldp_cycles", 64'(ldp_cycles), 64'd3);
        check("lb_res", 64'(last_res), 64'hFFFF_FF80);

        // LHU held while WB is busy, released next cycle from the buffer
        a = mk(3'b110, 2'd2, 32'h8001_1234, 32'h108);
        step(1, a, 0, 1, 0);
        step(0, a, 0, 0, 1);
        check("lhu_held_v", 64'(last_v), 64'd1);
        step(0, a, 0, 1, 0);
        check("lhu_release_v", 64'(last_v), 64'd1);
        check("lhu_res", 64'(last_res), 64'h0000_8001);

        // Flushed WAIT entry: its response is dropped, the next entry gets the following one
        a = mk(3'b000, 2'd0, 32'hAAAA_0001, 32'h10C);
        b = mk(3'b000, 2'd0, 32'hBBBB_0002, 32'h110);
        step(1, a, 0, 1, 0);
        step(0, a, 1, 1, 0);
        step(1, b, 0, 1, 0);
        step(0, b, 0, 1, 1);
        check("discard_drop_v", 64'(last_v), 64'd0);
        step(0, b, 0, 1, 1);
        check("discard_next_res", 64'(last_res), 64'hBBBB_0002);

        // Two owed responses saturate the discard count and block EX
        a = mk(3'b000, 2'd0, 32'hC0C0_0001, 32'h114);
        b = mk(3'b000, 2'd0, 32'hC0C0_0002, 32'h118);
        c = mk(3'b010, 2'd1, 32'h7FFF_9ABC, 32'h11C);
        step(1, a, 0, 1, 0);
        step(0, a, 1, 1, 0);
        step(1, b, 0, 1, 0);
        step(0, b, 1, 1, 0);
        step(1, c, 0, 1, 0);
        check("sat_block", 64'(last_allow), 64'd0);
        step(1, c, 0, 1, 1);
        check("sat_block_drain", 64'(last_allow), 64'd0);
        step(1, c, 0, 1, 0);
        check("sat_unblock", 64'(last_allow), 64'd1);
        step(0, c, 0, 1, 1);
        step(0, c, 0, 1, 1);
        check("sat_res", 64'(last_res), 64'hFFFF_9ABC);

        // Flush together with the entry's own response: nothing owed afterwards
        d = mk(3'b000, 2'd0, 32'hD0D0_0001, 32'h120);
        g = mk(3'b101, 2'd1, 32'h0000_F100, 32'h124);
        step(1, d, 0, 1, 0);
        step(0, d, 1, 1, 1);
        step(1, g, 0, 1, 0);
        step(0, g, 0, 1, 1);
        check("flush_resp_v", 64'(last_v), 64'd1);
        check("flush_resp_res", 64'(last_res), 64'h0000_00F1);

        // Reset asserted while an entry waits
        a = mk(3'b000, 2'd0, 32'h5555_AAAA, 32'h128);
        step(1, a, 0, 1, 0);
        step(0, a, 0, 1, 0);
        step(0, a, 0, 1, 0);
        resetn = 1'b0;
        #1;
        check("rstw_ws_valid", 64'(ms_to_ws_valid), 64'd0);
        check("rstw_allow", 64'(ms_allow_in), 64'd1);
        check("rstw_ds_bus", 64'(ms_to_ds_bus), 64'd0);
`ifdef MS_STALL_CNT_EN
        check("rstw_stall", 64'(ms_stall_cnt), 64'd0);
`endif
        q_dat.delete(); q_dead.delete(); m_has = 0; m_got = 0; m_stall = 0;
        es_to_ms_valid = 1'b0; ms_flush = 1'b0; data_sram_data_ok = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;

        // Random traffic
        n_retired = 0;
        id = 100;
        a = rand_ins(id);
        for (int cyc = 0; cyc < 2000; cyc++) begin
            ev = ($urandom_range(0, 3) != 0);
            fl = ($urandom_range(0, 15) == 0);
            wa = ($urandom_range(0, 3) != 0);
            dk = 1'($urandom_range(0, 1));
            step(ev, a, fl, wa, dk);
            if (last_acc) begin
                id++;
                a = rand_ins(id);
            end
        end
        check("random_progress", 64'(n_retired > 200), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
